// File: rtl/pipe_pkg.sv
// pipe_pkg - shared definitions for the RV64I pipeline controller.
//
// Contents:
//   XLEN_DEFAULT / CW_DEFAULT : default PC and performance-counter widths
//   S_*                       : bit positions inside the stall vector (IF..MEM)
//   F_*                       : bit positions inside the flush vector (ID..WB)
//   fsm_t                     : controller condition tracked for counters/debug
package pipe_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int CW_DEFAULT   = 32;

    // Stall vector: bit i holds the register feeding stage i+1 (PC, IF-ID, ID-EX, EX-MEM).
    localparam int S_IF  = 0;
    localparam int S_ID  = 1;
    localparam int S_EX  = 2;
    localparam int S_MEM = 3;

    // Flush vector: bit i bubbles the register in front of ID, EX, MEM, WB.
    localparam int F_ID  = 0;
    localparam int F_EX  = 1;
    localparam int F_MEM = 2;
    localparam int F_WB  = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        EX_WAIT  = 2'd2,
        REDIR    = 2'd3
    } fsm_t;

endpackage

// File: rtl/hazard_detect.sv
// hazard_detect - combinational load-use hazard compare.
//
// Flags a load-use hazard when the load in EX writes a register that the
// instruction in ID reads. x0 never creates a hazard. Kept separate so the
// forwarding unit can reuse the same compare.
//
// Ports:
//   rs1_ren, rs2_ren : ID reads rs1 / rs2
//   rs1, rs2         : ID source register numbers
//   ex_is_load       : EX holds a load
//   ex_rd            : EX destination register
//   lu               : load-use hazard present
module hazard_detect (
    input  logic       rs1_ren,
    input  logic       rs2_ren,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    output logic       lu
);

    logic hit_rs1;
    logic hit_rs2;

    assign hit_rs1 = rs1_ren && (rs1 == ex_rd);
    assign hit_rs2 = rs2_ren && (rs2 == ex_rd);
    assign lu      = ex_is_load && (hit_rs1 || hit_rs2) && (ex_rd != 5'd0);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - hazard and flow controller for the 5-stage RV64I pipeline.
//
// Produces per-stage stall/flush controls and the PC redirect, arbitrating
// (highest first) memory wait, EX multi-cycle wait, control-flow redirect,
// load-use hazard and fetch starvation / stale-fetch drop. Redirects that
// arrive during a wait are held and issued when the wait ends. Stall and
// flush outputs are combinational; pending state, FSM and counters are
// registered. Reset is synchronous, active-low.
//
// Ports:
//   clk, rst_n                   : clock, synchronous active-low reset
//   ifu_valid_i                  : fetch data for current PC present
//   ex_busy_i, lsu_busy_i        : EX multi-cycle op / MEM access not finished
//   id_rs*_ren_i, id_rs*_i       : ID source register reads
//   ex_is_load_i, ex_rd_i        : EX load and its destination
//   ex_redirect_i, ex_target_i   : taken branch/jump pulse and target
//   stall_*_o, flush_*_o         : pipeline register controls
//   redirect_o, redirect_pc_o    : PC redirect to fetch
//   stall_cnt_o, flush_cnt_o     : stall-cycle and redirect counters
//   state_o                      : current controller condition (debug)
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int CW   = CW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ifu_valid_i,
    input  logic            ex_busy_i,
    input  logic            lsu_busy_i,
    input  logic            id_rs1_ren_i,
    input  logic            id_rs2_ren_i,
    input  logic [4:0]      id_rs1_i,
    input  logic [4:0]      id_rs2_i,
    input  logic            ex_is_load_i,
    input  logic [4:0]      ex_rd_i,
    input  logic            ex_redirect_i,
    input  logic [XLEN-1:0] ex_target_i,
    output logic            stall_if_o,
    output logic            stall_id_o,
    output logic            stall_ex_o,
    output logic            stall_mem_o,
    output logic            flush_id_o,
    output logic            flush_ex_o,
    output logic            flush_mem_o,
    output logic            flush_wb_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic [CW-1:0]   stall_cnt_o,
    output logic [CW-1:0]   flush_cnt_o,
    output logic [1:0]      state_o
);

    fsm_t            state;
    logic            rd_pend;
    logic [XLEN-1:0] rd_pc;
    logic            drop;
    logic [CW-1:0]   stall_cnt;
    logic [CW-1:0]   flush_cnt;

    logic            lu;
    logic            mem_w;
    logic            ex_w;
    logic            redir_act;
    logic            drop_clr;
    logic [3:0]      stall;
    logic [3:0]      flush;

    hazard_detect u_hazard_detect (
        .rs1_ren    (id_rs1_ren_i),
        .rs2_ren    (id_rs2_ren_i),
        .rs1        (id_rs1_i),
        .rs2        (id_rs2_i),
        .ex_is_load (ex_is_load_i),
        .ex_rd      (ex_rd_i),
        .lu         (lu)
    );

    assign mem_w     = lsu_busy_i;
    assign ex_w      = ex_busy_i && !mem_w;
    // A redirect (fresh or held) only issues once no wait is active.
    assign redir_act = !mem_w && !ex_w && (ex_redirect_i || rd_pend);

    // NOTE: every signal gets a default before the priority chain so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        stall    = '0;
        flush    = '0;
        drop_clr = 1'b0;
        if (mem_w) begin
            stall          = 4'b1111;
            flush[F_WB]    = 1'b1;
        end else if (ex_w) begin
            stall[S_IF]    = 1'b1;
            stall[S_ID]    = 1'b1;
            stall[S_EX]    = 1'b1;
            flush[F_MEM]   = 1'b1;
        end else if (redir_act) begin
            // ID holds wrong-path code, so this beats any load-use hazard.
            flush[F_ID]    = 1'b1;
            flush[F_EX]    = 1'b1;
        end else if (lu) begin
            stall[S_IF]    = 1'b1;
            stall[S_ID]    = 1'b1;
            flush[F_EX]    = 1'b1;
        end else if (!ifu_valid_i || drop) begin
            // Starved fetch, or the stale response of a pre-redirect fetch.
            flush[F_ID]    = 1'b1;
            drop_clr       = drop && ifu_valid_i;
        end
    end

    // Reset forces a safe pipeline: everything bubbled, nothing held.
    assign stall_if_o    = rst_n && stall[S_IF];
    assign stall_id_o    = rst_n && stall[S_ID];
    assign stall_ex_o    = rst_n && stall[S_EX];
    assign stall_mem_o   = rst_n && stall[S_MEM];
    assign flush_id_o    = !rst_n || flush[F_ID];
    assign flush_ex_o    = !rst_n || flush[F_EX];
    assign flush_mem_o   = !rst_n || flush[F_MEM];
    assign flush_wb_o    = !rst_n || flush[F_WB];
    assign redirect_o    = rst_n && redir_act;
    assign redirect_pc_o = !rst_n ? '0 : (rd_pend ? rd_pc : ex_target_i);
    assign stall_cnt_o   = stall_cnt;
    assign flush_cnt_o   = flush_cnt;
    assign state_o       = state;

    // NOTE: reset is sampled on the clock edge only (synchronous); all
    // state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            rd_pend   <= 1'b0;
            rd_pc     <= '0;
            drop      <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (mem_w)          state <= MEM_WAIT;
            else if (ex_w)      state <= EX_WAIT;
            else if (redir_act) state <= REDIR;
            else                state <= RUN;

            if (redir_act) begin
                rd_pend <= 1'b0;
            end else if ((mem_w || ex_w) && ex_redirect_i) begin
                rd_pend <= 1'b1;
                rd_pc   <= ex_target_i;
            end

            // An outstanding fetch at redirect time returns wrong-path data.
            if (redir_act)     drop <= drop || !ifu_valid_i;
            else if (drop_clr) drop <= 1'b0;

            if (stall[S_IF]) stall_cnt <= stall_cnt + CW'(1);
            if (redir_act)   flush_cnt <= flush_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl - self-checking bench for pipe_ctrl.
//
// Directed scenarios compare against hand-derived constants; the random
// scenario compares against a reference model that classifies each cycle by
// the priority rules and tracks pending redirect, drop flag and counters.
module tb_pipe_ctrl;

    localparam int XLEN = 64;
    localparam int CW   = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ifu_valid_i;
    logic            ex_busy_i;
    logic            lsu_busy_i;
    logic            id_rs1_ren_i;
    logic            id_rs2_ren_i;
    logic [4:0]      id_rs1_i;
    logic [4:0]      id_rs2_i;
    logic            ex_is_load_i;
    logic [4:0]      ex_rd_i;
    logic            ex_redirect_i;
    logic [XLEN-1:0] ex_target_i;
    logic            stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
    logic            flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o;
    logic            redirect_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [CW-1:0]   stall_cnt_o;
    logic [CW-1:0]   flush_cnt_o;
    logic [1:0]      state_o;

    pipe_ctrl #(.XLEN(XLEN), .CW(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_valid_i   (ifu_valid_i),
        .ex_busy_i     (ex_busy_i),
        .lsu_busy_i    (lsu_busy_i),
        .id_rs1_ren_i  (id_rs1_ren_i),
        .id_rs2_ren_i  (id_rs2_ren_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .ex_is_load_i  (ex_is_load_i),
        .ex_rd_i       (ex_rd_i),
        .ex_redirect_i (ex_redirect_i),
        .ex_target_i   (ex_target_i),
        .stall_if_o    (stall_if_o),
        .stall_id_o    (stall_id_o),
        .stall_ex_o    (stall_ex_o),
        .stall_mem_o   (stall_mem_o),
        .flush_id_o    (flush_id_o),
        .flush_ex_o    (flush_ex_o),
        .flush_mem_o   (flush_mem_o),
        .flush_wb_o    (flush_wb_o),
        .redirect_o    (redirect_o),
        .redirect_pc_o (redirect_pc_o),
        .stall_cnt_o   (stall_cnt_o),
        .flush_cnt_o   (flush_cnt_o),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    // {stall IF,ID,EX,MEM, flush ID,EX,MEM,WB, redirect}
    logic [8:0] obs;
    assign obs = {stall_if_o, stall_id_o, stall_ex_o, stall_mem_o,
                  flush_id_o, flush_ex_o, flush_mem_o, flush_wb_o, redirect_o};

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic            m_pend;
    logic [XLEN-1:0] m_pc;
    logic            m_drop;
    logic [CW-1:0]   m_scnt;
    logic [CW-1:0]   m_fcnt;

    // Which priority case applies this cycle (0 = nothing to do).
    function automatic int pick_case();
        logic lu_ref;
        lu_ref = ex_is_load_i && (ex_rd_i != 5'd0) &&
                 ((id_rs1_ren_i && id_rs1_i == ex_rd_i) ||
                  (id_rs2_ren_i && id_rs2_i == ex_rd_i));
        if (lsu_busy_i)                    return 1;
        if (ex_busy_i)                     return 2;
        if (ex_redirect_i || m_pend)       return 3;
        if (lu_ref)                        return 4;
        if (!ifu_valid_i || m_drop)        return 5;
        return 0;
    endfunction

    function automatic logic [8:0] model_obs();
        if (!rst_n) return 9'b0000_1111_0;
        case (pick_case())
            1:       return 9'b1111_0001_0;
            2:       return 9'b1110_0010_0;
            3:       return 9'b0000_1100_1;
            4:       return 9'b1100_0100_0;
            5:       return 9'b0000_1000_0;
            default: return 9'b0000_0000_0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] model_pc();
        if (!rst_n) return '0;
        return m_pend ? m_pc : ex_target_i;
    endfunction

    // Advance one clock, updating the model from the pre-edge inputs.
    task automatic tick();
        int c;
        c = pick_case();
        @(posedge clk);
        if (!rst_n) begin
            m_pend = 1'b0; m_pc = '0; m_drop = 1'b0; m_scnt = '0; m_fcnt = '0;
        end else begin
            if (c == 1 || c == 2 || c == 4) m_scnt = m_scnt + 1;
            if (c == 3) begin
                m_fcnt = m_fcnt + 1;
                m_pend = 1'b0;
                if (!ifu_valid_i) m_drop = 1'b1;
            end
            if ((c == 1 || c == 2) && ex_redirect_i) begin
                m_pend = 1'b1;
                m_pc   = ex_target_i;
            end
            if (c == 5 && ifu_valid_i) m_drop = 1'b0;
        end
        #1;
    endtask

    task automatic idle();
        ifu_valid_i = 1'b1; ex_busy_i = 1'b0; lsu_busy_i = 1'b0;
        id_rs1_ren_i = 1'b0; id_rs2_ren_i = 1'b0; id_rs1_i = '0; id_rs2_i = '0;
        ex_is_load_i = 1'b0; ex_rd_i = '0; ex_redirect_i = 1'b0; ex_target_i = '0;
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        lsu_busy_i = 1'b1; ex_redirect_i = 1'b1; ex_target_i = 64'h1234;
        #1;
        n_vec++;
        if (obs !== 9'b0000_1111_0) begin
            n_err++; $display("FAIL reset_ctrl: got %b want %b", obs, 9'b0000_1111_0);
        end
        n_vec++;
        if (redirect_pc_o !== '0) begin
            n_err++; $display("FAIL reset_pc: got %h want 0", redirect_pc_o);
        end
        tick();
        rst_n = 1'b1;
        idle();
        #1;
        n_vec++;
        if (obs !== 9'b0 || stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
            n_err++; $display("FAIL reset_release: ctrl %b scnt %0d fcnt %0d want 0/0/0",
                              obs, stall_cnt_o, flush_cnt_o);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        ex_is_load_i = 1'b1; ex_rd_i = 5'd5; id_rs1_i = 5'd5; id_rs1_ren_i = 1'b1;
        id_rs2_i = 5'd7; id_rs2_ren_i = 1'b1;
        #1;
        n_vec++;
        if (obs !== 9'b1100_0100_0) begin
            n_err++; $display("FAIL lu_stall: got %b want %b", obs, 9'b1100_0100_0);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (obs !== 9'b0 || stall_cnt_o !== 32'd1) begin
            n_err++; $display("FAIL lu_after: ctrl %b scnt %0d want 0 / 1", obs, stall_cnt_o);
        end
        ex_is_load_i = 1'b1; ex_rd_i = 5'd0; id_rs1_i = 5'd0; id_rs1_ren_i = 1'b1;
        #1;
        n_vec++;
        if (obs !== 9'b0) begin
            n_err++; $display("FAIL lu_x0: got %b want %b", obs, 9'b0);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (stall_cnt_o !== 32'd1) begin
            n_err++; $display("FAIL lu_x0_cnt: got %0d want 1", stall_cnt_o);
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        ex_redirect_i = 1'b1; ex_target_i = 64'h8000_0040;
        #1;
        n_vec++;
        if (obs !== 9'b0000_1100_1 || redirect_pc_o !== 64'h8000_0040) begin
            n_err++; $display("FAIL redir_issue: ctrl %b pc %h want %b / 80000040",
                              obs, redirect_pc_o, 9'b0000_1100_1);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if (obs !== 9'b0 || flush_cnt_o !== 32'd1) begin
            n_err++; $display("FAIL redir_after: ctrl %b fcnt %0d want 0 / 1", obs, flush_cnt_o);
        end
    endtask

    task automatic test_redirect_mem_wait();
        apply_reset();
        for (int cyc = 0; cyc <= 5; cyc++) begin
            idle();
            lsu_busy_i    = (cyc <= 3);
            ex_redirect_i = (cyc == 1);
            ex_target_i   = (cyc == 1) ? 64'h100 : 64'hDEAD_0000;
            #1;
            if (cyc <= 3) begin
                n_vec++;
                if (obs !== 9'b1111_0001_0) begin
                    n_err++; $display("FAIL memwait_c%0d: got %b want %b", cyc, obs, 9'b1111_0001_0);
                end
            end else if (cyc == 4) begin
                n_vec++;
                if (obs !== 9'b0000_1100_1 || redirect_pc_o !== 64'h100) begin
                    n_err++; $display("FAIL memwait_issue: ctrl %b pc %h want %b / 100",
                                      obs, redirect_pc_o, 9'b0000_1100_1);
                end
            end else begin
                n_vec++;
                if (redirect_o !== 1'b0 || flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd4) begin
                    n_err++; $display("FAIL memwait_after: redir %b fcnt %0d scnt %0d want 0/1/4",
                                      redirect_o, flush_cnt_o, stall_cnt_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_stale_drop();
        logic [3:0] want_fl [4];
        logic       valid   [4];
        want_fl = '{4'b1100, 4'b1000, 4'b1000, 4'b0000};
        valid   = '{1'b0, 1'b0, 1'b1, 1'b1};
        apply_reset();
        for (int cyc = 0; cyc < 4; cyc++) begin
            idle();
            ifu_valid_i   = valid[cyc];
            ex_redirect_i = (cyc == 0);
            ex_target_i   = 64'h200;
            #1;
            n_vec++;
            if (obs[4:1] !== want_fl[cyc]) begin
                n_err++; $display("FAIL drop_c%0d: flush %b want %b", cyc, obs[4:1], want_fl[cyc]);
            end
            tick();
        end
    endtask

    task automatic test_priority();
        apply_reset();
        lsu_busy_i = 1'b1; ex_busy_i = 1'b1;
        ex_is_load_i = 1'b1; ex_rd_i = 5'd9; id_rs2_i = 5'd9; id_rs2_ren_i = 1'b1;
        #1;
        n_vec++;
        if (obs !== 9'b1111_0001_0) begin
            n_err++; $display("FAIL prio_mem: got %b want %b", obs, 9'b1111_0001_0);
        end
        lsu_busy_i = 1'b0;
        #1;
        n_vec++;
        if (obs !== 9'b1110_0010_0) begin
            n_err++; $display("FAIL prio_ex: got %b want %b", obs, 9'b1110_0010_0);
        end
        ex_busy_i = 1'b0; ex_redirect_i = 1'b1; ex_target_i = 64'h44;
        #1;
        n_vec++;
        if (obs !== 9'b0000_1100_1) begin
            n_err++; $display("FAIL prio_redir: got %b want %b", obs, 9'b0000_1100_1);
        end
        idle();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        lsu_busy_i = 1'b1;
        tick();
        ex_redirect_i = 1'b1; ex_target_i = 64'h300;
        tick();
        ex_redirect_i = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 9'b0000_1111_0) begin
            n_err++; $display("FAIL rstwait_in: got %b want %b", obs, 9'b0000_1111_0);
        end
        tick();
        rst_n = 1'b1;
        idle();
        for (int cyc = 0; cyc < 2; cyc++) begin
            #1;
            n_vec++;
            if (redirect_o !== 1'b0 || stall_cnt_o !== '0 || flush_cnt_o !== '0) begin
                n_err++; $display("FAIL rstwait_out%0d: redir %b scnt %0d fcnt %0d want 0/0/0",
                                  cyc, redirect_o, stall_cnt_o, flush_cnt_o);
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic [8:0]      e_obs;
        logic [XLEN-1:0] e_pc;
        apply_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rst_n         = ($urandom_range(0, 99) != 0);
            ifu_valid_i   = ($urandom_range(0, 3) != 0);
            ex_busy_i     = ($urandom_range(0, 4) == 0);
            lsu_busy_i    = ($urandom_range(0, 6) == 0);
            id_rs1_ren_i  = 1'($urandom);
            id_rs2_ren_i  = 1'($urandom);
            id_rs1_i      = 5'($urandom_range(0, 3));
            id_rs2_i      = 5'($urandom_range(0, 3));
            ex_is_load_i  = ($urandom_range(0, 2) == 0);
            ex_rd_i       = 5'($urandom_range(0, 3));
            // A second pulse is only legal once the held one has issued.
            ex_redirect_i = !m_pend && ($urandom_range(0, 7) == 0);
            ex_target_i   = {$urandom, $urandom};
            #1;
            e_obs = model_obs();
            e_pc  = model_pc();
            n_vec++;
            if (obs !== e_obs) begin
                n_err++; $display("FAIL rnd_ctrl c%0d: got %b want %b", cyc, obs, e_obs);
            end
            n_vec++;
            if (redirect_pc_o !== e_pc) begin
                n_err++; $display("FAIL rnd_pc c%0d: got %h want %h", cyc, redirect_pc_o, e_pc);
            end
            n_vec++;
            if (stall_cnt_o !== m_scnt || flush_cnt_o !== m_fcnt) begin
                n_err++; $display("FAIL rnd_cnt c%0d: scnt %0d/%0d fcnt %0d/%0d (got/want)",
                                  cyc, stall_cnt_o, m_scnt, flush_cnt_o, m_fcnt);
            end
            tick();
        end
    endtask

    initial begin
        m_pend = 1'b0; m_pc = '0; m_drop = 1'b0; m_scnt = '0; m_fcnt = '0;
        rst_n = 1'b0;
        idle();
        #2;
        test_reset();
        test_load_use();
        test_redirect();
        test_redirect_mem_wait();
        test_stale_drop();
        test_priority();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
